memory_test_sequencer: RTL and testbench

MEMORY_TEST_SEQUENCER -- requirements
Module: memory_test_sequencer

---
 rtl/memory_test_pkg.sv | 28 ++
 rtl/mem_test_checker.sv | 60 ++++++
 rtl/memory_test_sequencer.sv | 116 +++++++++++
 tb/tb_memory_test_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_test_pkg.sv
// Shared types and constants for the memory test sequencer slice.
// Latency: n/a (types, constants and the pattern helper only).
// Backpressure: n/a.
package memory_test_pkg;

  localparam int MEM_DEPTH = 8;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam addr_t LAST_ADDR = addr_t'(MEM_DEPTH - 1);

  // Test pattern for one location: seed plus address, wrapping at 8 bits.
  function automatic data_t pattern(input data_t seed, input addr_t addr);
    return seed + data_t'(addr);
  endfunction

endpackage

// File: rtl/mem_test_checker.sv
// Aligns read addresses with returning data, compares against the pattern, counts mismatches.
// Latency: compare happens READ_LATENCY+1 edges after the edge that presents the address.
// Backpressure: none; one compare slot per cycle, pipeline flushed by reset.
module mem_test_checker
  import memory_test_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        issue_vld,
  input  addr_t       issue_addr,
  input  data_t       seed,
  input  data_t       mem_dout,
  output logic        mismatch,
  output logic [3:0]  fail_count,
  output addr_t       first_fail_addr
);

  logic  cmp_vld;
  addr_t cmp_addr;

  if (READ_LATENCY == 0) begin : g_lat0
    // Combinational-read memory: data belongs to the address currently presented.
    assign cmp_vld  = issue_vld;
    assign cmp_addr = issue_addr;
  end else begin : g_lat1
    logic  vld_q;
    addr_t addr_q;

    // One-stage expected-address delay matching the registered memory read.
    always_ff @(posedge clk) begin
      if (!rst) begin
        vld_q  <= 1'b0;
        addr_q <= '0;
      end else begin
        vld_q  <= issue_vld;
        addr_q <= issue_addr;
      end
    end

    assign cmp_vld  = vld_q;
    assign cmp_addr = addr_q;
  end

  assign mismatch = cmp_vld && (mem_dout != pattern(seed, cmp_addr));

  // Mismatch accounting; first mismatch of a run is the lowest address since reads ascend.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      fail_count      <= '0;
      first_fail_addr <= '0;
    end else if (mismatch) begin
      fail_count <= fail_count + 4'd1;
      if (fail_count == 4'd0) first_fail_addr <= cmp_addr;
    end
  end

endmodule

// File: rtl/memory_test_sequencer.sv
// Writes a seed-based pattern to an 8x8 memory, reads it back and reports mismatches.
// Latency: done pulses 16+READ_LATENCY edges after the accepted start edge.
// Backpressure: none; start is ignored unless the sequencer is idle.
module memory_test_sequencer
  import memory_test_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [3:0]        fail_count,
  output logic [ADDR_W-1:0] first_fail_addr
);

  localparam logic LAT0 = (READ_LATENCY == 0);

  state_e state;
  data_t  seed_q;
  logic   accept;
  logic   mismatch;

  assign accept = (state == ST_IDLE) && start;

  // Run control: write pass, read pass, drain of the compare pipe, one-cycle done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      seed_q   <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_WRITE;
            seed_q   <= seed;
            mem_we   <= 1'b1;
            mem_addr <= '0;
            mem_din  <= seed;
            busy     <= 1'b1;
            pass     <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (mem_addr == LAST_ADDR) begin
            state    <= ST_READ;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
          end else begin
            mem_addr <= mem_addr + 3'd1;
            mem_din  <= pattern(seed_q, mem_addr + 3'd1);
          end
        end
        ST_READ: begin
          if (mem_addr == LAST_ADDR) begin
            mem_addr <= '0;
            if (LAT0) begin
              // Last compare happens on this edge; there is nothing left to drain.
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= (fail_count == 4'd0) && !mismatch;
            end else begin
              state <= ST_DRAIN;
            end
          end else begin
            mem_addr <= mem_addr + 3'd1;
          end
        end
        ST_DRAIN: begin
          state <= ST_DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (fail_count == 4'd0) && !mismatch;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  mem_test_checker #(
    .READ_LATENCY(READ_LATENCY)
  ) u_checker (
    .clk             (clk),
    .rst             (rst),
    .clr             (accept),
    .issue_vld       (state == ST_READ),
    .issue_addr      (mem_addr),
    .seed            (seed_q),
    .mem_dout        (mem_dout),
    .mismatch        (mismatch),
    .fail_count      (fail_count),
    .first_fail_addr (first_fail_addr)
  );

endmodule

// File: tb/tb_memory_test_sequencer.sv
// Self-checking bench: one sequencer with a registered-read memory, one with a combinational-read memory.
// Latency: done expected 16+READ_LATENCY edges after the start edge (17 edges / 18th cycle for latency 1).
// Backpressure: n/a; write and result scoreboards are filled when a run is launched.
module tb_memory_test_sequencer;
  import memory_test_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start1, start0, fault;
  logic [7:0] seed;

  logic       we1, busy1, done1, pass1, we0, busy0, done0, pass0;
  logic [2:0] addr1, ffa1, addr0, ffa0;
  logic [7:0] din1, dout1, din0, dout0;
  logic [3:0] fc1, fc0;

  logic [7:0] mem1 [8];
  logic [7:0] mem0 [8];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt1 = 0;
  int done_cnt0 = 0;

  typedef struct {
    logic       lat0;
    logic       flt;
    logic [7:0] sd;
    logic [3:0] fc;
    logic [2:0] ffa;
    logic       ps;
  } vec_t;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t  wr_q [$];
  vec_t res_q [$];
  vec_t vecs [7];

  memory_test_sequencer #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .seed(seed),
    .mem_we(we1), .mem_addr(addr1), .mem_din(din1), .mem_dout(dout1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1), .first_fail_addr(ffa1)
  );

  memory_test_sequencer #(.READ_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .seed(seed),
    .mem_we(we0), .mem_addr(addr0), .mem_din(din0), .mem_dout(dout0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_count(fc0), .first_fail_addr(ffa0)
  );

  // Optional fault: bit0 stuck at 0 at addresses 3 and 5.
  function automatic logic [7:0] stored(input logic [2:0] a, input logic [7:0] d);
    return (fault && (a == 3'd3 || a == 3'd5)) ? {d[7:1], 1'b0} : d;
  endfunction

  // Registered-read memory model.
  always @(posedge clk) begin
    if (we1) mem1[addr1] <= stored(addr1, din1);
    dout1 <= mem1[addr1];
  end

  // Combinational-read memory model.
  always @(posedge clk) begin
    if (we0) mem0[addr0] <= stored(addr0, din0);
  end
  assign dout0 = mem0[addr0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every write must match the next scoreboard entry.
  always @(negedge clk) begin
    wr_t w;
    if (we1 || we0) begin
      if (wr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 we1 ? addr1 : addr0, we1 ? din1 : din0);
      end else begin
        w = wr_q.pop_front();
        check("wr_addr", 32'(we1 ? addr1 : addr0), 32'(w.a));
        check("wr_data", 32'(we1 ? din1 : din0), 32'(w.d));
      end
    end
    if (done1) done_cnt1++;
    if (done0) done_cnt0++;
  end

  task automatic push_writes(input logic [7:0] sd);
    for (int a = 0; a < 8; a++) wr_q.push_back('{a[2:0], sd + 8'(a)});
  endtask

  // Launch one run, optionally pulse start again at cycle 'glitch', then check the result.
  task automatic run_vec(input vec_t v, input int glitch);
    int   n;
    bit   seen;
    vec_t r;
    fault = v.flt;
    @(negedge clk);
    seed = v.sd;
    if (v.lat0) start0 = 1'b1; else start1 = 1'b1;
    push_writes(v.sd);
    res_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    check("busy_after_start", 32'(v.lat0 ? busy0 : busy1), 32'd1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      if (v.lat0 ? done0 : done1) begin
        seen = 1'b1;
      end else begin
        if (n == glitch) begin
          seed = 8'h55;
          if (v.lat0) start0 = 1'b1; else start1 = 1'b1;
        end else begin
          start0 = 1'b0;
          start1 = 1'b0;
        end
        @(negedge clk);
        n++;
      end
    end
    start0 = 1'b0;
    start1 = 1'b0;
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles expected done", n);
    end else begin
      r = res_q.pop_front();
      check("done_latency", 32'(n), v.lat0 ? 32'd16 : 32'd17);
      check("fail_count", 32'(v.lat0 ? fc0 : fc1), 32'(r.fc));
      check("first_fail_addr", 32'(v.lat0 ? ffa0 : ffa1), 32'(r.ffa));
      check("pass", 32'(v.lat0 ? pass0 : pass1), 32'(r.ps));
      check("busy_in_done", 32'(v.lat0 ? busy0 : busy1), 32'd0);
      @(negedge clk);
      check("done_one_cycle", 32'(v.lat0 ? done0 : done1), 32'd0);
      check("pass_held", 32'(v.lat0 ? pass0 : pass1), 32'(r.ps));
      check("fail_count_held", 32'(v.lat0 ? fc0 : fc1), 32'(r.fc));
    end
    check("write_scoreboard_empty", 32'(wr_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int d0;
    //         lat0  flt   seed   fc    ffa   pass
    vecs[0] = '{1'b0, 1'b0, 8'h00, 4'd0, 3'd0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 8'hFC, 4'd0, 3'd0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 4'd2, 3'd3, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 4'd0, 3'd0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 8'h01, 4'd0, 3'd0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 8'h02, 4'd2, 3'd3, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 8'hFF, 4'd0, 3'd0, 1'b1};

    rst = 1'b0; start1 = 1'b0; start0 = 1'b0; seed = 8'h00; fault = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs_lat1", 32'({we1, addr1, din1, busy1, done1, pass1, fc1, ffa1}), 32'd0);
    check("reset_outs_lat0", 32'({we0, addr0, din0, busy0, done0, pass0, fc0, ffa0}), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], -1);

    // Start re-pulsed mid-write with a different seed: must be ignored, single done.
    d0 = done_cnt1;
    run_vec('{1'b0, 1'b0, 8'h10, 4'd0, 3'd0, 1'b1}, 3);
    repeat (30) @(negedge clk);
    check("single_done_after_glitch", 32'(done_cnt1 - d0), 32'd1);

    // Reset during the 4th write cycle: outputs clear, no done.
    fault = 1'b0;
    @(negedge clk);
    seed = 8'h20;
    start1 = 1'b1;
    push_writes(8'h20);
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (!(we1 && addr1 == 3'd3) && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) begin
      n_checks++;
      n_fail++;
      $display("FAIL fourth_write_timeout: got no write to addr 3 expected one");
    end
    d0 = done_cnt1;
    rst = 1'b0;
    @(negedge clk);
    check("midrun_reset_outs", 32'({we1, addr1, din1, busy1, done1, pass1, fc1, ffa1}), 32'd0);
    wr_q.delete();
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("no_done_after_reset", 32'(done_cnt1 - d0), 32'd0);
    check("idle_after_reset", 32'({we1, busy1}), 32'd0);

    // Fresh run after the aborted one must be clean.
    run_vec(vecs[2], -1);
    run_vec(vecs[0], -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
